// File: rtl/sweep_pkg.sv
// Shared types and constants for the frequency-sweep controller.
package sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_REPORT,
        S_DONE
    } state_t;

    // Source for the saturated |min| magnitude: sliced to the sample width at the use site.
    localparam logic [63:0] ABS_SAT_ONES = '1;

endpackage

// File: rtl/sweep_if.sv
// Result handshake bundle: one measured peak per frequency point.
interface sweep_if #(
    parameter int CNT_W = 16,
    parameter int LC_DW = 12
);
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_idx;
    logic [LC_DW-2:0] res_peak;

    modport master (output res_valid, res_idx, res_peak, input res_ready);
    modport slave  (input res_valid, res_idx, res_peak, output res_ready);
endinterface

// File: rtl/sweep_ctrl_peak_abs.sv
// Saturating magnitude and running-peak tracker over one measurement window.
module peak_abs
    import sweep_pkg::*;
#(
    parameter int LC_DW = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    update,
    input  logic signed [LC_DW-1:0] x,
    output logic        [LC_DW-2:0] peak
);

    localparam logic [LC_DW-1:0] XMIN = {1'b1, {(LC_DW-1){1'b0}}};
    localparam logic [LC_DW-2:0] SAT  = ABS_SAT_ONES[LC_DW-2:0];

    logic [LC_DW-1:0] neg;
    logic [LC_DW-2:0] mag;

    always_comb begin
        neg = -x;
        if (!x[LC_DW-1])
            mag = x[LC_DW-2:0];
        else if (x == XMIN)
            mag = SAT;
        else
            mag = neg[LC_DW-2:0];
    end

    // clear together with update starts a fresh window with the current sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            peak <= '0;
        else if (update)
            peak <= (clear || (mag > peak)) ? mag : peak;
        else if (clear)
            peak <= '0;
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Stepped DDS frequency sweep: settle, measure peak |filtered|, report, advance.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int FREQ_DW = 32,
    parameter int LC_DW   = 12,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    start,
    input  logic                    abort,
    input  logic [FREQ_DW-1:0]      f_start,
    input  logic [FREQ_DW-1:0]      f_step,
    input  logic [CNT_W-1:0]        n_steps,
    input  logic [CNT_W-1:0]        settle,
    input  logic [CNT_W-1:0]        dwell,
    input  logic signed [LC_DW-1:0] filtered,
    output logic [FREQ_DW-1:0]      freq,
    output logic                    busy,
    output logic                    done,
    sweep_if.master                 res
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state;
    logic [FREQ_DW-1:0] step_q;
    logic [CNT_W-1:0]   n_q, settle_q, dwell_q;
    logic [CNT_W-1:0]   cnt, idx, dwell_last;
    logic [LC_DW-2:0]   peak;
    logic               pk_clr, pk_upd;

    // dwell of zero still measures one sample.
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - CNT_ONE;
    assign pk_upd     = en && (state == S_MEASURE);
    assign pk_clr     = pk_upd && (cnt == '0);

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign res.res_valid = (state == S_REPORT);
    assign res.res_idx   = idx;
    assign res.res_peak  = peak;

    peak_abs #(.LC_DW(LC_DW)) u_peak (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (pk_clr),
        .update (pk_upd),
        .x      (filtered),
        .peak   (peak)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            freq     <= '0;
            step_q   <= '0;
            n_q      <= '0;
            settle_q <= '0;
            dwell_q  <= '0;
            cnt      <= '0;
            idx      <= '0;
        end else if (en) begin
            if (abort) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    S_IDLE: if (start) begin
                        step_q   <= f_step;
                        n_q      <= n_steps;
                        settle_q <= settle;
                        dwell_q  <= dwell;
                        freq     <= f_start;
                        idx      <= '0;
                        cnt      <= '0;
                        if (n_steps == '0)
                            state <= S_DONE;
                        else if (settle == '0)
                            state <= S_MEASURE;
                        else
                            state <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (cnt == settle_q - CNT_ONE) begin
                            cnt   <= '0;
                            state <= S_MEASURE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_MEASURE: begin
                        if (cnt == dwell_last) begin
                            cnt   <= '0;
                            state <= S_REPORT;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_REPORT: if (res.res_ready) begin
                        if (idx == n_q - CNT_ONE) begin
                            state <= S_DONE;
                        end else begin
                            freq  <= freq + step_q;
                            idx   <= idx + CNT_ONE;
                            state <= (settle_q == '0) ? S_MEASURE : S_SETTLE;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
